// File: rtl/instruction_decode_if.sv
// Fetch/decode boundary bundle: control in, decoded fields and redirect out.
// Decode owns the slave side; the fetch stage (or a bench) owns the master side.
interface instruction_decode_if #(
  parameter int INSN_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  _run;
  logic                  _stall;
  logic                  _zeroFlag;
  logic [INSN_WIDTH-1:0] instruction;
  logic                  fetchHold;
  logic                  _branchJump;
  logic                  _relative;
  logic [DATA_WIDTH-1:0] _destBranchJump;
  logic [3:0]            opcode;
  logic [3:0]            rd;
  logic [3:0]            rs;
  logic [DATA_WIDTH-1:0] imm;
  logic                  decValid;
  logic                  haltReq;

  modport slave (
    input  _run, _stall, _zeroFlag, instruction,
    output fetchHold, _branchJump, _relative, _destBranchJump,
           opcode, rd, rs, imm, decValid, haltReq
  );

  modport master (
    output _run, _stall, _zeroFlag, instruction,
    input  fetchHold, _branchJump, _relative, _destBranchJump,
           opcode, rd, rs, imm, decValid, haltReq
  );
endinterface

// File: rtl/instruction_decode.sv
// Decode register + jump/branch resolution; fields 1 edge after capture, redirect combinational.
// _stall holds the register and suppresses redirects; fetchHold freezes fetch in IDLE/HALTED/stall.
module instruction_decode #(
  parameter int INSN_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input logic                _CLK,
  input logic                _reset,
  instruction_decode_if.slave dec
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALTED} state_e;

  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_BR   = 4'hB;
  localparam logic [3:0] OP_BEQZ = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e                state_q, state_d;
  logic [INSN_WIDTH-1:0] insn_q, insn_d;
  logic                  dec_valid_q, dec_valid_d;
  logic                  halt_req_q, halt_req_d;

  logic [3:0]            op;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic                  live;
  logic                  take_rel;
  logic                  take_jump;
  logic                  retire_halt;
  logic                  capture;

  assign op      = insn_q[INSN_WIDTH-1 -: 4];
  assign imm_ext = DATA_WIDTH'($signed(insn_q[7:0]));

  // A held or dying (_run low) instruction must never redirect fetch.
  assign live        = dec_valid_q & ~dec._stall & dec._run & (state_q == RUN);
  assign take_rel    = live & ((op == OP_BR) | ((op == OP_BEQZ) & dec._zeroFlag));
  assign take_jump   = take_rel | (live & (op == OP_JMP));
  assign retire_halt = live & (op == OP_HALT);

  // The word arriving on the redirect edge is the wrong-path one, so it is not loaded.
  assign capture = dec._run & ~dec._stall &
                   ((state_q == FLUSH) |
                    ((state_q == RUN) & ~retire_halt & ~take_jump));

  always_comb begin
    state_d     = state_q;
    insn_d      = insn_q;
    dec_valid_d = dec_valid_q;
    halt_req_d  = halt_req_q;

    if (capture) begin
      insn_d      = dec.instruction;
      dec_valid_d = 1'b1;
      if (dec.instruction[INSN_WIDTH-1 -: 4] == OP_HALT) begin
        halt_req_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        dec_valid_d = 1'b0;
        if (dec._run) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!dec._run) begin
          state_d     = IDLE;
          dec_valid_d = 1'b0;
        end else if (retire_halt) begin
          state_d     = HALTED;
          dec_valid_d = 1'b0;
        end else if (take_jump) begin
          state_d     = FLUSH;
          dec_valid_d = 1'b0;
        end
      end
      FLUSH: begin
        if (!dec._run) begin
          state_d     = IDLE;
          dec_valid_d = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      HALTED: begin
        dec_valid_d = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        dec_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge _CLK or posedge _reset) begin
    if (_reset) begin
      state_q     <= IDLE;
      insn_q      <= '0;
      dec_valid_q <= 1'b0;
      halt_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      insn_q      <= insn_d;
      dec_valid_q <= dec_valid_d;
      halt_req_q  <= halt_req_d;
    end
  end

  assign dec.opcode          = op;
  assign dec.rd              = insn_q[11:8];
  assign dec.rs              = insn_q[7:4];
  assign dec.imm             = imm_ext;
  assign dec.decValid        = dec_valid_q;
  assign dec.haltReq         = halt_req_q;
  assign dec._branchJump     = take_jump;
  assign dec._relative       = take_rel;
  assign dec._destBranchJump = take_jump ? imm_ext : '0;
  assign dec.fetchHold       = dec._stall | (state_q == HALTED) | (state_q == IDLE);
endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: expected outputs are queued with each stimulus step
// and popped for comparison once the DUT has responded.
`timescale 1ns/1ps
module tb_instruction_decode;
  logic clk;
  logic rst;

  instruction_decode_if #(.INSN_WIDTH(16), .DATA_WIDTH(8)) bus ();

  instruction_decode #(.INSN_WIDTH(16), .DATA_WIDTH(8)) dut (
    ._CLK  (clk),
    ._reset(rst),
    .dec   (bus.slave)
  );

  typedef struct packed {
    logic       dv;
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [7:0] imm;
    logic       bj;
    logic       rel;
    logic [7:0] dest;
    logic       fh;
    logic       hr;
  } out_t;

  out_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  function automatic out_t mk(logic dv, logic [3:0] op, logic [3:0] rd, logic [3:0] rs,
                              logic [7:0] imm, logic bj, logic rel, logic [7:0] dest,
                              logic fh, logic hr);
    out_t o;
    o.dv = dv; o.op = op; o.rd = rd; o.rs = rs; o.imm = imm;
    o.bj = bj; o.rel = rel; o.dest = dest; o.fh = fh; o.hr = hr;
    return o;
  endfunction

  task automatic compare(input string tag);
    out_t obs;
    out_t exp;
    obs.dv = bus.decValid;  obs.op = bus.opcode; obs.rd = bus.rd; obs.rs = bus.rs;
    obs.imm = bus.imm;      obs.bj = bus._branchJump; obs.rel = bus._relative;
    obs.dest = bus._destBranchJump; obs.fh = bus.fetchHold; obs.hr = bus.haltReq;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed dv=%0b op=%h rd=%h rs=%h imm=%h bj=%0b rel=%0b dest=%h fh=%0b hr=%0b required dv=%0b op=%h rd=%h rs=%h imm=%h bj=%0b rel=%0b dest=%h fh=%0b hr=%0b",
               tag, obs.dv, obs.op, obs.rd, obs.rs, obs.imm, obs.bj, obs.rel, obs.dest, obs.fh, obs.hr,
               exp.dv, exp.op, exp.rd, exp.rs, exp.imm, exp.bj, exp.rel, exp.dest, exp.fh, exp.hr);
      end
    end
  endtask

  // Drive inputs for the next rising edge, then check the state settled after it.
  task automatic step(input string tag, input logic [15:0] insn, input logic run,
                      input logic stall, input logic zf, input out_t exp);
    bus.instruction = insn;
    bus._run        = run;
    bus._stall      = stall;
    bus._zeroFlag   = zf;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  // Change reset/run/stall between edges and check the immediate response.
  task automatic poke(input string tag, input logic r, input logic run, input logic stall,
                      input out_t exp);
    rst        = r;
    bus._run   = run;
    bus._stall = stall;
    exp_q.push_back(exp);
    #1;
    compare(tag);
  endtask

  out_t rst_v;

  initial begin
    rst_v = mk(0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 8'h00, 1, 0);
    rst = 1'b1;
    bus._run = 1'b0; bus._stall = 1'b0; bus._zeroFlag = 1'b0; bus.instruction = 16'h0000;
    #2;
    exp_q.push_back(rst_v);
    compare("reset");
    #6 rst = 1'b0;

    // Straight-line decode
    step("idle2run", 16'h1120, 1, 0, 0, mk(0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 8'h00, 0, 0));
    step("add",      16'h1120, 1, 0, 0, mk(1, 4'h1, 4'h1, 4'h2, 8'h20, 0, 0, 8'h00, 0, 0));
    step("ldi",      16'h3205, 1, 0, 0, mk(1, 4'h3, 4'h2, 4'h0, 8'h05, 0, 0, 8'h00, 0, 0));

    // Absolute jump, squash, resume
    step("jmp",        16'hA00E, 1, 0, 0, mk(1, 4'hA, 4'h0, 4'h0, 8'h0E, 1, 0, 8'h0E, 0, 0));
    step("jmp_squash", 16'h5123, 1, 0, 0, mk(0, 4'hA, 4'h0, 4'h0, 8'h0E, 0, 0, 8'h00, 0, 0));
    step("jmp_resume", 16'h1340, 1, 0, 0, mk(1, 4'h1, 4'h3, 4'h4, 8'h40, 0, 0, 8'h00, 0, 0));

    // Relative branch, BEQZ not taken / taken
    step("br",         16'hB0FD, 1, 0, 0, mk(1, 4'hB, 4'h0, 4'hF, 8'hFD, 1, 1, 8'hFD, 0, 0));
    step("br_squash",  16'h2000, 1, 0, 0, mk(0, 4'hB, 4'h0, 4'hF, 8'hFD, 0, 0, 8'h00, 0, 0));
    step("beqz_nt",    16'hC0FD, 1, 0, 0, mk(1, 4'hC, 4'h0, 4'hF, 8'hFD, 0, 0, 8'h00, 0, 0));
    step("no_bubble",  16'h1111, 1, 0, 0, mk(1, 4'h1, 4'h1, 4'h1, 8'h11, 0, 0, 8'h00, 0, 0));
    step("beqz_t",     16'hC0FD, 1, 0, 1, mk(1, 4'hC, 4'h0, 4'hF, 8'hFD, 1, 1, 8'hFD, 0, 0));
    step("beqz_squash",16'h2222, 1, 0, 1, mk(0, 4'hC, 4'h0, 4'hF, 8'hFD, 0, 0, 8'h00, 0, 0));

    // Branch held under stall redirects once, after release
    step("br2_cap",    16'hB0FD, 1, 0, 0, mk(1, 4'hB, 4'h0, 4'hF, 8'hFD, 1, 1, 8'hFD, 0, 0));
    poke("br2_stall_on", 0, 1, 1,         mk(1, 4'hB, 4'h0, 4'hF, 8'hFD, 0, 0, 8'h00, 1, 0));
    for (int i = 0; i < 3; i++)
      step($sformatf("br2_stall%0d", i), 16'h1234, 1, 1, 0,
           mk(1, 4'hB, 4'h0, 4'hF, 8'hFD, 0, 0, 8'h00, 1, 0));
    poke("br2_release", 0, 1, 0,          mk(1, 4'hB, 4'h0, 4'hF, 8'hFD, 1, 1, 8'hFD, 0, 0));
    step("br2_squash", 16'h9999, 1, 0, 0, mk(0, 4'hB, 4'h0, 4'hF, 8'hFD, 0, 0, 8'h00, 0, 0));
    step("br2_resume", 16'h1120, 1, 0, 0, mk(1, 4'h1, 4'h1, 4'h2, 8'h20, 0, 0, 8'h00, 0, 0));

    // _run falling beats a pending redirect
    step("run_jmp",     16'hA00E, 1, 0, 0, mk(1, 4'hA, 4'h0, 4'h0, 8'h0E, 1, 0, 8'h0E, 0, 0));
    poke("run_drop", 0, 0, 0,              mk(1, 4'hA, 4'h0, 4'h0, 8'h0E, 0, 0, 8'h00, 0, 0));
    step("run_idle",    16'h1111, 0, 0, 0, mk(0, 4'hA, 4'h0, 4'h0, 8'h0E, 0, 0, 8'h00, 1, 0));
    step("run_restart", 16'h1111, 1, 0, 0, mk(0, 4'hA, 4'h0, 4'h0, 8'h0E, 0, 0, 8'h00, 0, 0));

    // HALT is sticky until reset
    step("halt_cap", 16'hF000, 1, 0, 0, mk(1, 4'hF, 4'h0, 4'h0, 8'h00, 0, 0, 8'h00, 0, 1));
    step("halted",   16'h1120, 1, 0, 0, mk(0, 4'hF, 4'h0, 4'h0, 8'h00, 0, 0, 8'h00, 1, 1));
    for (int i = 0; i < 2; i++)
      step($sformatf("halted_ign%0d", i), 16'hA00E, 1, 0, 0,
           mk(0, 4'hF, 4'h0, 4'h0, 8'h00, 0, 0, 8'h00, 1, 1));
    poke("halt_rst",     1, 1, 0, rst_v);
    poke("halt_rst_rel", 0, 1, 0, rst_v);

    // Asynchronous reset in the middle of a flush bubble
    step("f_idle2run", 16'h0000, 1, 0, 0, mk(0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 8'h00, 0, 0));
    step("f_jmp",      16'hA00E, 1, 0, 0, mk(1, 4'hA, 4'h0, 4'h0, 8'h0E, 1, 0, 8'h0E, 0, 0));
    step("f_flush",    16'h5555, 1, 0, 0, mk(0, 4'hA, 4'h0, 4'h0, 8'h0E, 0, 0, 8'h00, 0, 0));
    poke("flush_rst",     1, 1, 0, rst_v);
    poke("flush_rst_rel", 0, 1, 0, rst_v);
    step("f2_idle2run", 16'h1120, 1, 0, 0, mk(0, 4'h0, 4'h0, 4'h0, 8'h00, 0, 0, 8'h00, 0, 0));
    step("f2_first",    16'h3205, 1, 0, 0, mk(1, 4'h3, 4'h2, 4'h0, 8'h05, 0, 0, 8'h00, 0, 0));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
